fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised next-generation forwarding unit for the 5-stage pipeline.
- Combines the EX-stage operand forwarding selects (independent A and B paths) with a sequential load-use hazard controller.
- The controller stalls IF/ID and bubbles ID/EX for a configurable number of load-latency cycles and keeps a saturating stall-cycle counter.
- Sits beside the ID/EX register; drives the EX operand muxes, PC write enable and IF/ID write enable.

Parameters:
- REG_AW, 5, register address width; register 0 is hardwired zero and is never forwarded or hazard-matched.
- LOAD_LAT, 1, load-use stall cycles per detected hazard (legal range 1..15).
- STAT_W, 16, width of the stall_cycles statistics counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ex_mem_RegWrite  in  1  EX/MEM stage writes the register file.
- ex_mem_RegisterRd  in  REG_AW  EX/MEM destination register.
- mem_wb_RegWrite  in  1  MEM/WB stage writes the register file.
- mem_wb_RegisterRd  in  REG_AW  MEM/WB destination register.
- id_ex_RegisterRs  in  REG_AW  EX-stage source operand A.
- id_ex_RegisterRt  in  REG_AW  EX-stage source operand B.
- id_ex_MemRead  in  1  EX-stage instruction is a load.
- if_id_RegisterRs  in  REG_AW  ID-stage source 1.
- if_id_RegisterRt  in  REG_AW  ID-stage source 2.
- ex_flush  in  1  branch/jump flush from EX; aborts any stall.
- ForwardA  out  2  operand A select: 00 regfile, 01 EX/MEM, 10 MEM/WB.
- ForwardB  out  2  operand B select; same encoding as ForwardA.
- pc_write  out  1  PC write enable (0 = hold).
- if_id_write  out  1  IF/ID write enable (0 = hold).
- id_ex_bubble  out  1  zero the ID/EX control fields this cycle.
- stall_cycles  out  STAT_W  saturating count of stalled cycles.

Behaviour:
- Forwarding is purely combinational; ForwardA is driven only from the Rs compare and ForwardB only from the Rt compare.
  - Select 01 when ex_mem_RegWrite is set, ex_mem_RegisterRd != 0, and ex_mem_RegisterRd equals the source.
  - Otherwise select 10 when the same test passes for the MEM/WB stage.
  - Otherwise select 00.
  - EX/MEM always wins over MEM/WB.
- hazard = id_ex_MemRead && id_ex_RegisterRt != 0 && (id_ex_RegisterRt == if_id_RegisterRs || id_ex_RegisterRt == if_id_RegisterRt).
- stall (internal, combinational) = !reset && !ex_flush && ((state==RUN && hazard) || state==STALL).
- pc_write = if_id_write = !stall; id_ex_bubble = stall.
- FSM states: RUN, STALL; a 4-bit down-counter cnt.
  - RUN, hazard, no flush: stall this cycle. If LOAD_LAT==1, stay in RUN. If LOAD_LAT>1, go to STALL with cnt = LOAD_LAT-1.
  - STALL: stall every cycle. When cnt==1, go to RUN with cnt=0; otherwise decrement cnt.
  - Total stall length is exactly LOAD_LAT cycles per hazard.
  - While in STALL, new hazard evaluation is ignored; the load instruction is already past ID/EX.
  - ex_flush in any state: no stall that cycle; next state RUN; cnt=0. Flush takes priority over hazard.
- stall_cycles increments by 1 on every cycle where stall=1, and saturates at 2^STAT_W-1 with no wrap.
- Reset (synchronous, asserted at an edge): next state RUN, cnt=0, stall_cycles=0.
  - While reset is high: pc_write=1, if_id_write=1, id_ex_bubble=0.
  - ForwardA/ForwardB still follow their inputs during reset.
  - Reset mid-STALL abandons the stall immediately; the first cycle after reset deassertion is in RUN.

Optional Feature:
- Macro: FWD_LATE_WB_EN.
- Defined:
  - Adds ports wb_late_RegWrite (in, 1) and wb_late_RegisterRd (in, REG_AW) for the write-through stage after MEM/WB.
  - Select 11 chooses that source, at lowest priority below 10 and subject to the same nonzero-register and RegWrite rules.
- Undefined:
  - The ports do not exist; selects are only ever 00/01/10.

Test Plan:
- Fwd priority: ex_mem Rd=3 W=1 and mem_wb Rd=3 W=1, id_ex Rs=3 Rt=3 -> ForwardA=01, ForwardB=01; clear ex_mem_RegWrite -> 10/10.
- Zero and independence: ex_mem Rd=0 W=1, id_ex Rs=0 -> ForwardA=00. Then ex_mem Rd=5, id_ex Rs=5 Rt=6 -> ForwardA=01, ForwardB=00.
- Load-use, LOAD_LAT=1: id_ex_MemRead=1, id_ex Rt=7, if_id Rs=7 for one cycle, then MemRead=0 -> exactly 1 cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cycles=1.
- Load-use, LOAD_LAT=3: same stimulus -> 3 consecutive stall cycles, then RUN; stall_cycles=3. A second hazard later -> stall_cycles=6.
- Flush abort, LOAD_LAT=3: hazard at cycle 0, ex_flush=1 at cycle 1 -> stall only in cycle 0, pc_write=1 from cycle 1; stall_cycles=1.
- Reset mid-stall, plus saturation with STAT_W=2:
  - Reset asserted in STALL -> pc_write=1 that cycle, stall_cycles=0 next cycle.
  - Five stall cycles -> stall_cycles holds at 3.

Source files
------------

// File: rtl/fwd_hazard_unit_if.sv
// Bundle between the pipeline control path and the forwarding/hazard unit.
// The write-through stage ports exist only when FWD_LATE_WB_EN is defined.
interface fwd_hazard_unit_if #(
    parameter int REG_AW = 5,
    parameter int STAT_W = 16
);
    logic              ex_mem_RegWrite;
    logic [REG_AW-1:0] ex_mem_RegisterRd;
    logic              mem_wb_RegWrite;
    logic [REG_AW-1:0] mem_wb_RegisterRd;
`ifdef FWD_LATE_WB_EN
    logic              wb_late_RegWrite;
    logic [REG_AW-1:0] wb_late_RegisterRd;
`endif
    logic [REG_AW-1:0] id_ex_RegisterRs;
    logic [REG_AW-1:0] id_ex_RegisterRt;
    logic              id_ex_MemRead;
    logic [REG_AW-1:0] if_id_RegisterRs;
    logic [REG_AW-1:0] if_id_RegisterRt;
    logic              ex_flush;
    logic [1:0]        ForwardA;
    logic [1:0]        ForwardB;
    logic              pc_write;
    logic              if_id_write;
    logic              id_ex_bubble;
    logic [STAT_W-1:0] stall_cycles;

    modport master (
`ifdef FWD_LATE_WB_EN
        output wb_late_RegWrite, wb_late_RegisterRd,
`endif
        output ex_mem_RegWrite, ex_mem_RegisterRd,
        output mem_wb_RegWrite, mem_wb_RegisterRd,
        output id_ex_RegisterRs, id_ex_RegisterRt, id_ex_MemRead,
        output if_id_RegisterRs, if_id_RegisterRt, ex_flush,
        input  ForwardA, ForwardB, pc_write, if_id_write,
        input  id_ex_bubble, stall_cycles
    );

    modport slave (
`ifdef FWD_LATE_WB_EN
        input  wb_late_RegWrite, wb_late_RegisterRd,
`endif
        input  ex_mem_RegWrite, ex_mem_RegisterRd,
        input  mem_wb_RegWrite, mem_wb_RegisterRd,
        input  id_ex_RegisterRs, id_ex_RegisterRt, id_ex_MemRead,
        input  if_id_RegisterRs, if_id_RegisterRt, ex_flush,
        output ForwardA, ForwardB, pc_write, if_id_write,
        output id_ex_bubble, stall_cycles
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding selects plus a load-use stall controller with a
// saturating stall counter. Define FWD_LATE_WB_EN to add the select-11 source.
module fwd_hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int STAT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    fwd_hazard_unit_if.slave  bus
);

    typedef enum logic {RUN, STALL} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [STAT_W-1:0] stallCnt_q, stallCnt_d;
    logic              hazard;
    logic              stall;

    logic exHitA, exHitB, wbHitA, wbHitB, lateHitA, lateHitB;

    // Each producer matches only a nonzero destination that is being written.
    always_comb begin
        exHitA = bus.ex_mem_RegWrite && (bus.ex_mem_RegisterRd != '0)
                 && (bus.ex_mem_RegisterRd == bus.id_ex_RegisterRs);
        exHitB = bus.ex_mem_RegWrite && (bus.ex_mem_RegisterRd != '0)
                 && (bus.ex_mem_RegisterRd == bus.id_ex_RegisterRt);
        wbHitA = bus.mem_wb_RegWrite && (bus.mem_wb_RegisterRd != '0)
                 && (bus.mem_wb_RegisterRd == bus.id_ex_RegisterRs);
        wbHitB = bus.mem_wb_RegWrite && (bus.mem_wb_RegisterRd != '0)
                 && (bus.mem_wb_RegisterRd == bus.id_ex_RegisterRt);
`ifdef FWD_LATE_WB_EN
        lateHitA = bus.wb_late_RegWrite && (bus.wb_late_RegisterRd != '0)
                   && (bus.wb_late_RegisterRd == bus.id_ex_RegisterRs);
        lateHitB = bus.wb_late_RegWrite && (bus.wb_late_RegisterRd != '0)
                   && (bus.wb_late_RegisterRd == bus.id_ex_RegisterRt);
`else
        lateHitA = 1'b0;
        lateHitB = 1'b0;
`endif
    end

    always_comb begin
        bus.ForwardA = 2'b00;
        if (exHitA)        bus.ForwardA = 2'b01;
        else if (wbHitA)   bus.ForwardA = 2'b10;
        else if (lateHitA) bus.ForwardA = 2'b11;

        bus.ForwardB = 2'b00;
        if (exHitB)        bus.ForwardB = 2'b01;
        else if (wbHitB)   bus.ForwardB = 2'b10;
        else if (lateHitB) bus.ForwardB = 2'b11;
    end

    assign hazard = bus.id_ex_MemRead && (bus.id_ex_RegisterRt != '0)
                    && ((bus.id_ex_RegisterRt == bus.if_id_RegisterRs)
                        || (bus.id_ex_RegisterRt == bus.if_id_RegisterRt));

    // The hazard cycle itself is the first stall cycle, so STALL covers the
    // remaining LOAD_LAT-1 cycles; flush and reset abort it outright.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        if (bus.ex_flush) begin
            state_d = RUN;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hazard) begin
                        stall = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = STALL;
                            cnt_d   = 4'(LOAD_LAT - 1);
                        end
                    end
                end
                STALL: begin
                    stall = 1'b1;
                    if (cnt_q == 4'd1) begin
                        state_d = RUN;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 4'd0;
                end
            endcase
        end
        if (reset) stall = 1'b0;
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (stall && (stallCnt_q != {STAT_W{1'b1}})) stallCnt_d = stallCnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            cnt_q      <= 4'd0;
            stallCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign bus.pc_write     = !stall;
    assign bus.if_id_write  = !stall;
    assign bus.id_ex_bubble = stall;
    assign bus.stall_cycles = stallCnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: two instances (LOAD_LAT=3/STAT_W=16 and LOAD_LAT=1/STAT_W=2)
// share one stimulus stream and are checked against a remaining-stall-count model.
module tb_fwd_hazard_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.REG_AW(5), .STAT_W(16)) ifA ();
    fwd_hazard_unit_if #(.REG_AW(5), .STAT_W(2))  ifB ();

    fwd_hazard_unit #(.REG_AW(5), .LOAD_LAT(3), .STAT_W(16)) dutA (
        .clk(clk), .reset(rst), .bus(ifA.slave)
    );
    fwd_hazard_unit #(.REG_AW(5), .LOAD_LAT(1), .STAT_W(2)) dutB (
        .clk(clk), .reset(rst), .bus(ifB.slave)
    );

    typedef struct packed {
        logic       rst, flush, exW, wbW, memRead, lateW;
        logic [4:0] exRd, wbRd, idRs, idRt, ifRs, ifRt, lateRd;
    } stim_t;

    typedef struct packed {
        logic [1:0]  fa, fb;
        logic        stallA, stallB;
        logic [15:0] cntA;
        logic [1:0]  cntB;
    } exp_t;

    exp_t queue_q[$];
    int   total = 0;
    int   bad   = 0;
    int   remA = 0, remB = 0, cntA = 0, cntB = 0;

    function automatic logic [1:0] refFwd(stim_t s, logic [4:0] src);
        if (src == 5'd0) return 2'b00;
        if (s.exW && s.exRd == src) return 2'b01;
        if (s.wbW && s.wbRd == src) return 2'b10;
`ifdef FWD_LATE_WB_EN
        if (s.lateW && s.lateRd == src) return 2'b11;
`endif
        return 2'b00;
    endfunction

    task automatic cmp(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0d expected=%0d at %0t", name, got, want, $time);
        end
    endtask

    // Model: a hazard starts lat stall cycles, counted down as "remaining".
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        logic hz;
        @(posedge clk);
        #1;
        rst = s.rst;
        ifA.ex_mem_RegWrite = s.exW;      ifB.ex_mem_RegWrite = s.exW;
        ifA.ex_mem_RegisterRd = s.exRd;   ifB.ex_mem_RegisterRd = s.exRd;
        ifA.mem_wb_RegWrite = s.wbW;      ifB.mem_wb_RegWrite = s.wbW;
        ifA.mem_wb_RegisterRd = s.wbRd;   ifB.mem_wb_RegisterRd = s.wbRd;
        ifA.id_ex_RegisterRs = s.idRs;    ifB.id_ex_RegisterRs = s.idRs;
        ifA.id_ex_RegisterRt = s.idRt;    ifB.id_ex_RegisterRt = s.idRt;
        ifA.id_ex_MemRead = s.memRead;    ifB.id_ex_MemRead = s.memRead;
        ifA.if_id_RegisterRs = s.ifRs;    ifB.if_id_RegisterRs = s.ifRs;
        ifA.if_id_RegisterRt = s.ifRt;    ifB.if_id_RegisterRt = s.ifRt;
        ifA.ex_flush = s.flush;           ifB.ex_flush = s.flush;
`ifdef FWD_LATE_WB_EN
        ifA.wb_late_RegWrite = s.lateW;   ifB.wb_late_RegWrite = s.lateW;
        ifA.wb_late_RegisterRd = s.lateRd; ifB.wb_late_RegisterRd = s.lateRd;
`endif
        hz = s.memRead && s.idRt != 5'd0 && (s.idRt == s.ifRs || s.idRt == s.ifRt);
        e.fa     = refFwd(s, s.idRs);
        e.fb     = refFwd(s, s.idRt);
        e.stallA = !s.rst && !s.flush && (remA > 0 || hz);
        e.stallB = !s.rst && !s.flush && (remB > 0 || hz);
        e.cntA   = 16'(cntA);
        e.cntB   = 2'(cntB);
        queue_q.push_back(e);
        if (s.rst) begin
            remA = 0; remB = 0; cntA = 0; cntB = 0;
        end else begin
            if (e.stallA && cntA < 65535) cntA++;
            if (e.stallB && cntB < 3) cntB++;
            if (s.flush) remA = 0;
            else if (remA > 0) remA--;
            else if (hz) remA = 3 - 1;
            if (s.flush) remB = 0;
            else if (remB > 0) remB--;
            else if (hz) remB = 1 - 1;
        end
    endtask

    task automatic checkOutput(input exp_t e);
        cmp("A.ForwardA", int'(ifA.ForwardA), int'(e.fa));
        cmp("A.ForwardB", int'(ifA.ForwardB), int'(e.fb));
        cmp("B.ForwardA", int'(ifB.ForwardA), int'(e.fa));
        cmp("B.ForwardB", int'(ifB.ForwardB), int'(e.fb));
        cmp("A.pc_write", int'(ifA.pc_write), int'(!e.stallA));
        cmp("A.if_id_write", int'(ifA.if_id_write), int'(!e.stallA));
        cmp("A.id_ex_bubble", int'(ifA.id_ex_bubble), int'(e.stallA));
        cmp("A.stall_cycles", int'(ifA.stall_cycles), int'(e.cntA));
        cmp("B.pc_write", int'(ifB.pc_write), int'(!e.stallB));
        cmp("B.if_id_write", int'(ifB.if_id_write), int'(!e.stallB));
        cmp("B.id_ex_bubble", int'(ifB.id_ex_bubble), int'(e.stallB));
        cmp("B.stall_cycles", int'(ifB.stall_cycles), int'(e.cntB));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (queue_q.size() > 0) checkOutput(queue_q.pop_front());
        end
    end

    task automatic idle(input int n);
        stim_t s;
        s = '0;
        for (int i = 0; i < n; i++) applyStimulus(s);
    endtask

    task automatic loadUse();
        stim_t s;
        s = '0;
        s.memRead = 1'b1; s.idRt = 5'd7; s.ifRs = 5'd7;
        applyStimulus(s);
    endtask

    initial begin
        stim_t s;
        s = '0;
        s.rst = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        applyStimulus(s);

        // Forwarding priority, zero register and A/B independence
        s = '0; s.exW = 1; s.exRd = 3; s.wbW = 1; s.wbRd = 3; s.idRs = 3; s.idRt = 3;
        applyStimulus(s);
        s.exW = 0;
        applyStimulus(s);
        s = '0; s.exW = 1; s.exRd = 0; s.idRs = 0;
        applyStimulus(s);
        s = '0; s.exW = 1; s.exRd = 5; s.idRs = 5; s.idRt = 6;
        applyStimulus(s);

        // Load-use hazards, then a second one
        loadUse(); idle(4);
        loadUse(); idle(4);

        // Flush one cycle after the hazard
        loadUse();
        s = '0; s.flush = 1;
        applyStimulus(s);
        idle(3);

        // Reset while dutA is mid-stall
        loadUse(); idle(1);
        s = '0; s.rst = 1;
        applyStimulus(s);
        idle(2);

        // Five consecutive hazard cycles saturate the 2-bit counter
        for (int i = 0; i < 5; i++) loadUse();
        idle(4);

        for (int i = 0; i < 3000; i++) begin
            s.rst     = ($urandom_range(0, 59) == 0);
            s.flush   = ($urandom_range(0, 11) == 0);
            s.exW     = 1'($urandom_range(0, 1));
            s.wbW     = 1'($urandom_range(0, 1));
            s.lateW   = 1'($urandom_range(0, 1));
            s.memRead = ($urandom_range(0, 2) == 0);
            s.exRd    = 5'($urandom_range(0, 3));
            s.wbRd    = 5'($urandom_range(0, 3));
            s.lateRd  = 5'($urandom_range(0, 3));
            s.idRs    = 5'($urandom_range(0, 3));
            s.idRt    = 5'($urandom_range(0, 3));
            s.ifRs    = 5'($urandom_range(0, 3));
            s.ifRt    = 5'($urandom_range(0, 3));
            applyStimulus(s);
        end

        repeat (3) @(posedge clk);
        if (queue_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain got=%0d expected=0 pending", queue_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
